// File: rtl/aes_block_sequencer_if.sv
// Signal bundle for aes_block_sequencer: upstream block stream, AES core cipher bus,
// downstream result stream and status. The sequencer uses the master modport.
interface aes_block_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic             in_ende;
  logic [TAG_W-1:0] in_tag;
  logic             key_ready;
  logic             core_ready;
  logic [127:0]     core_i_data;
  logic             core_i_data_valid;
  logic             core_i_ende;
  logic             core_i_enable;
  logic [127:0]     core_o_data;
  logic             core_o_data_valid;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             out_ende;
  logic [TAG_W-1:0] out_tag;
  logic [15:0]      blk_count;
  logic             timeout_err;

  modport master (
    input  in_valid, in_data, in_ende, in_tag, key_ready, core_ready,
           core_o_data, core_o_data_valid, out_ready,
    output in_ready, core_i_data, core_i_data_valid, core_i_ende, core_i_enable,
           out_valid, out_data, out_ende, out_tag, blk_count, timeout_err
  );

  modport slave (
    output in_valid, in_data, in_ende, in_tag, key_ready, core_ready,
           core_o_data, core_o_data_valid, out_ready,
    input  in_ready, core_i_data, core_i_data_valid, core_i_ende, core_i_enable,
           out_valid, out_data, out_ende, out_tag, blk_count, timeout_err
  );
endinterface

// File: rtl/aes_block_sequencer.sv
// One-block-in-flight sequencer between a valid/ready block stream and the AES core cipher bus.
// Optional result watchdog (sticky timeout_err) is enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_block_sequencer #(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  resetH,
  aes_block_sequencer_if.master io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_CORE   = 2'd1,
    ST_WAIT_RESULT = 2'd2,
    ST_HOLD_OUT    = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_cfg_check
    $error("aes_block_sequencer: TIMEOUT_CYCLES must be in 1..65536");
  end

  state_t           r_state;
  logic [127:0]     r_hold_data;
  logic             r_hold_ende;
  logic [TAG_W-1:0] r_hold_tag;
  logic [127:0]     r_core_i_data;
  logic             r_core_i_data_valid;
  logic             r_core_i_ende;
  logic             r_core_i_enable;
  logic             r_out_valid;
  logic [127:0]     r_out_data;
  logic             r_out_ende;
  logic [TAG_W-1:0] r_out_tag;
  logic [15:0]      r_blk_count;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_result;

`ifdef AES_SEQ_TIMEOUT_EN
  localparam logic [15:0] LP_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic        r_timeout_err;
  logic [15:0] r_wait_cnt;
  assign io_bus.timeout_err = r_timeout_err;
`else
  assign io_bus.timeout_err = 1'b0;
`endif

  assign w_in_ready = (r_state == ST_IDLE) && io_bus.key_ready && !resetH;
  assign w_accept   = io_bus.in_valid && w_in_ready;
  // The core's valid is not trusted during the start-pulse cycle itself.
  assign w_result   = io_bus.core_o_data_valid && !r_core_i_data_valid;

  assign io_bus.in_ready          = w_in_ready;
  assign io_bus.core_i_data       = r_core_i_data;
  assign io_bus.core_i_data_valid = r_core_i_data_valid;
  assign io_bus.core_i_ende       = r_core_i_ende;
  assign io_bus.core_i_enable     = r_core_i_enable;
  assign io_bus.out_valid         = r_out_valid;
  assign io_bus.out_data          = r_out_data;
  assign io_bus.out_ende          = r_out_ende;
  assign io_bus.out_tag           = r_out_tag;
  assign io_bus.blk_count         = r_blk_count;

  // Sequencer FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (resetH) begin
      r_state             <= ST_IDLE;
      r_hold_data         <= 128'd0;
      r_hold_ende         <= 1'b0;
      r_hold_tag          <= {TAG_W{1'b0}};
      r_core_i_data       <= 128'd0;
      r_core_i_data_valid <= 1'b0;
      r_core_i_ende       <= 1'b0;
      r_core_i_enable     <= 1'b0;
      r_out_valid         <= 1'b0;
      r_out_data          <= 128'd0;
      r_out_ende          <= 1'b0;
      r_out_tag           <= {TAG_W{1'b0}};
      r_blk_count         <= 16'd0;
`ifdef AES_SEQ_TIMEOUT_EN
      r_timeout_err       <= 1'b0;
      r_wait_cnt          <= 16'd0;
`endif
    end else begin
      r_core_i_data_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_hold_data <= io_bus.in_data;
            r_hold_ende <= io_bus.in_ende;
            r_hold_tag  <= io_bus.in_tag;
            r_state     <= ST_WAIT_CORE;
          end
        end
        ST_WAIT_CORE: begin
          if (io_bus.core_ready) begin
            r_core_i_data       <= r_hold_data;
            r_core_i_ende       <= r_hold_ende;
            r_core_i_data_valid <= 1'b1;
            r_core_i_enable     <= 1'b1;
            r_state             <= ST_WAIT_RESULT;
`ifdef AES_SEQ_TIMEOUT_EN
            r_wait_cnt          <= 16'd0;
`endif
          end
        end
        ST_WAIT_RESULT: begin
          // A result on the watchdog's final cycle still wins.
          if (w_result) begin
            r_out_data  <= io_bus.core_o_data;
            r_out_ende  <= r_hold_ende;
            r_out_tag   <= r_hold_tag;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD_OUT;
          end
`ifdef AES_SEQ_TIMEOUT_EN
          else if (r_wait_cnt == LP_TIMEOUT_LAST) begin
            r_timeout_err   <= 1'b1;
            r_core_i_enable <= 1'b0;
            r_state         <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
`endif
        end
        ST_HOLD_OUT: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_blk_count <= r_blk_count + 16'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
